cp0_exception_sequencer: RTL
============================

# cp0_exception_sequencer

Sequences all CP0 side effects of an exception or `eret` taken in the MEM stage, and shares CP0's single write port with ordinary `mtc0` writes retiring from WB. The block serialises the writes to BadVAddr, EPC, Cause and Status over successive cycles. While it works it stalls and flushes the pipeline, then issues a single PC redirect. It sits between the WB/MEM stages and the CP0 register file, next to the CP0 read forwarding logic, which supplies its current Status/Cause/EPC view.

## Interface
- `EXC_VECTOR`, default 32'hBFC0_0380: exception handler entry PC.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `wb_cp0_write_flag`  in  1  `mtc0` retiring in WB.
- `wb_cp0_write_addr`  in  8  {reg[4:0], sel[2:0]}.
- `wb_cp0_data_in`  in  32  `mtc0` data.
- `cp0_status_in`, `cp0_cause_in`, `cp0_epc_in`  in  32 each  forwarded CP0 view, WB-bypassed.
- `exc_valid`  in  1  MEM-stage exception request, one-cycle pulse.
- `exc_code`  in  5  ExcCode.
- `exc_pc`  in  32  PC of the faulting instruction.
- `exc_in_delay_slot`  in  1  faulting instruction is in a branch delay slot.
- `exc_badvaddr_valid`  in  1  a BadVAddr write is required.
- `exc_badvaddr`  in  32  faulting address.
- `eret_valid`  in  1  `eret` in MEM, one-cycle pulse.
- `cp0_write_flag`  out  1  CP0 write-port enable.
- `cp0_write_addr`  out  8  CP0 write-port address.
- `cp0_write_data`  out  32  CP0 write-port data.
- `stall_req`  out  1  freeze the front end.
- `flush`  out  1  kill all IF..MEM contents.
- `redirect_valid`  out  1  load `redirect_pc` into the PC.
- `redirect_pc`  out  32  next fetch PC.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, W_BADV, W_EPC, W_CAUSE, W_STATUS, E_STATUS, REDIRECT.
- Write port in IDLE is a combinational pass-through of the WB `mtc0`. In every other state the port is driven only by the FSM, and `wb_cp0_write_flag` is ignored. A WB write while busy is a protocol violation; the bench asserts it never occurs.
- Acceptance happens in IDLE only. `exc_valid` beats `eret_valid` when both are high. At acceptance, latch:
  - the request fields;
  - `status_l`, `cause_l`, `epc_l`: the `*_in` value, replaced by `wb_cp0_data_in` when WB writes that register in the same cycle.
- `exl_l = status_l[1]`.
- Exception path: W_BADV (only if `exc_badvaddr_valid`) → W_EPC (only if `!exl_l`) → W_CAUSE → W_STATUS → REDIRECT → IDLE.
  - W_BADV writes addr 0x40, data `exc_badvaddr`.
  - W_EPC writes addr 0x70, data `exc_in_delay_slot ? exc_pc-4 : exc_pc` (32-bit wrap).
  - W_CAUSE writes addr 0x68, data `cause_l` with [6:2]=`exc_code`. Bit 31 = `exc_in_delay_slot` if `!exl_l`, else unchanged.
  - W_STATUS writes addr 0x60, data `status_l | 32'h2`.
  - REDIRECT drives `redirect_pc = EXC_VECTOR`.
- Eret path: E_STATUS writes addr 0x60, data `status_l & ~32'h2`. Then REDIRECT drives `redirect_pc = epc_l`.
- Exactly one CP0 write per write state, each lasting one cycle.

## Timing
- Reset: state = IDLE. All FSM outputs and latches are 0 on the next edge. `cp0_write_*` then follows WB. `rst` mid-sequence aborts with no further writes or redirect.
- Acceptance edge t; the first FSM state is active in cycle t+1.
- `flush` is high for exactly cycle t+1.
- `stall_req` and `busy` are high from t+1 through the REDIRECT cycle inclusive.
- `redirect_valid` is high for one cycle, in REDIRECT. IDLE resumes the following cycle, and new requests are accepted only there.
- Full exception with BadVAddr and EXL=0: writes at t+1..t+4, redirect at t+5, idle at t+6.
- Skipped states cost no cycle.
- Eret: write at t+1, redirect at t+2.
- Requests arriving while busy are dropped. The pipeline guarantees none arrive, because it is flushed.

## Structure
- Shared CP0 define header holds:
  - CP0 address constants: BADVADDR 0x40, STATUS 0x60, CAUSE 0x68, EPC 0x70;
  - ExcCode constants;
  - the state encodings;
  - the default `EXC_VECTOR`.
- No sub-module: one FSM, one latch bank, one output mux.

## Test plan
- AdEL, BadVAddr valid, EXL=0, `exc_pc`=0xBFC0_0100, Status=0x0040_0000:
  - t+1 BADV=addr; t+2 EPC=0xBFC0_0100; t+3 Cause[6:2]=4, bit31=0; t+4 Status=0x0040_0002;
  - t+5 redirect to 0xBFC0_0380.
- Syscall in delay slot, `exc_pc`=0x8000_0010, EXL=0 → EPC=0x8000_000C, Cause bit31=1, ExcCode=8; no BadVAddr write; redirect at t+4.
- Exception with Status EXL=1 → no EPC write; Cause BD preserved; writes only at t+1 (Cause) and t+2 (Status); redirect at t+3.
- WB `mtc0` Status=0x0000_0001 in the acceptance cycle → that write passes through at t; the W_STATUS write is 0x0000_0003.
- Eret with EPC=0x8000_2000, Status=0x3 → t+1 Status=0x1; t+2 redirect to 0x8000_2000; `exc_valid`+`eret_valid` together → exception path taken.
- `rst` asserted at t+2 of the exception path → next cycle busy=0, no writes and no redirect follow.

Source files
------------

// File: rtl/cp0_exception_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cp0_exception_sequencer_pkg
// Shared CP0 definitions for the exception sequencer:
//   - CP0 write-port addresses ({reg[4:0], sel[2:0]}) for BadVAddr/Status/Cause/EPC
//   - MIPS ExcCode values
//   - sequencer state encoding and the latched request record
//   - default exception handler vector
//   - small helpers that build the EPC/Cause write data and the WB bypass
// -----------------------------------------------------------------------------
package cp0_exception_sequencer_pkg;

  // CP0 register addresses as seen on the write port
  localparam logic [7:0] CP0_ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_ADDR_STATUS   = 8'h60;
  localparam logic [7:0] CP0_ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_ADDR_EPC      = 8'h70;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_IBE  = 5'd6;
  localparam logic [4:0] EXC_DBE  = 5'd7;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_EXL_MASK    = 32'h0000_0002;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_BADV   = 3'd1,
    W_EPC    = 3'd2,
    W_CAUSE  = 3'd3,
    W_STATUS = 3'd4,
    E_STATUS = 3'd5,
    REDIRECT = 3'd6
  } seq_state_e;

  // Everything captured at acceptance; the sequence runs only from this copy.
  typedef struct packed {
    logic        is_eret;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        in_ds;
    logic        badv_valid;
    logic [31:0] badvaddr;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
  } exc_req_t;

  // Restart PC: a delay-slot fault restarts at the branch (wraps at 32 bits).
  function automatic logic [31:0] epc_value(input logic [31:0] pc, input logic in_ds);
    return in_ds ? (pc - 32'd4) : pc;
  endfunction

  // Cause update: ExcCode always replaced; BD only refreshed when not already in EXL.
  function automatic logic [31:0] cause_value(input logic [31:0] cause, input logic [4:0] code,
                                              input logic in_ds, input logic exl);
    logic [31:0] c;
    c      = cause;
    c[6:2] = code;
    if (!exl) begin
      c[31] = in_ds;
    end else begin
      c[31] = cause[31];
    end
    return c;
  endfunction

  // Same-cycle WB mtc0 to a register wins over the forwarded view.
  function automatic logic [31:0] wb_bypass(input logic [31:0] cur, input logic wb_flag,
                                            input logic [7:0] wb_addr, input logic [31:0] wb_data,
                                            input logic [7:0] addr);
    return (wb_flag && (wb_addr == addr)) ? wb_data : cur;
  endfunction

endpackage

// File: rtl/cp0_exception_sequencer_if.sv
// -----------------------------------------------------------------------------
// cp0_exception_sequencer_if
// Bundles the pipeline-side signals of the exception sequencer.
//   inputs to the sequencer : WB mtc0 (flag/addr/data), forwarded Status/Cause/EPC,
//                             MEM exception request fields, eret request
//   outputs of the sequencer: CP0 write port, stall/flush, PC redirect, busy
// modport slave  : the sequencer itself
// modport master : the pipeline / environment driving it
// -----------------------------------------------------------------------------
interface cp0_exception_sequencer_if;

  logic        wb_cp0_write_flag;
  logic [7:0]  wb_cp0_write_addr;
  logic [31:0] wb_cp0_data_in;
  logic [31:0] cp0_status_in;
  logic [31:0] cp0_cause_in;
  logic [31:0] cp0_epc_in;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_delay_slot;
  logic        exc_badvaddr_valid;
  logic [31:0] exc_badvaddr;
  logic        eret_valid;

  logic        cp0_write_flag;
  logic [7:0]  cp0_write_addr;
  logic [31:0] cp0_write_data;
  logic        stall_req;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    output wb_cp0_write_flag, wb_cp0_write_addr, wb_cp0_data_in,
           cp0_status_in, cp0_cause_in, cp0_epc_in,
           exc_valid, exc_code, exc_pc, exc_in_delay_slot,
           exc_badvaddr_valid, exc_badvaddr, eret_valid,
    input  cp0_write_flag, cp0_write_addr, cp0_write_data,
           stall_req, flush, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  wb_cp0_write_flag, wb_cp0_write_addr, wb_cp0_data_in,
           cp0_status_in, cp0_cause_in, cp0_epc_in,
           exc_valid, exc_code, exc_pc, exc_in_delay_slot,
           exc_badvaddr_valid, exc_badvaddr, eret_valid,
    output cp0_write_flag, cp0_write_addr, cp0_write_data,
           stall_req, flush, redirect_valid, redirect_pc, busy
  );

endinterface

// File: rtl/cp0_exception_sequencer.sv
// -----------------------------------------------------------------------------
// cp0_exception_sequencer
// Serialises the CP0 side effects of an exception or eret taken in MEM
// (BadVAddr, EPC, Cause, Status writes, one per cycle), then issues one PC
// redirect. Shares the single CP0 write port with WB mtc0: in IDLE the port is
// a combinational pass-through of WB, otherwise the FSM owns it.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - cp0_exception_sequencer_if.slave (requests in; write port,
//          stall/flush/redirect/busy out)
// Parameter:
//   EXC_VECTOR - exception handler entry PC
// -----------------------------------------------------------------------------
module cp0_exception_sequencer
  import cp0_exception_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  cp0_exception_sequencer_if.slave    bus
);

  seq_state_e  state_q, state_d;
  exc_req_t    req_q, req_d;
  logic        accept_s;
  logic        exl_s;

  logic        wr_flag_q, wr_flag_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        flush_q, flush_d;
  logic        busy_q, busy_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  // Request acceptance and latch-bank capture (exception beats eret).
  always_comb begin
    req_d    = req_q;
    accept_s = (state_q == IDLE) && (bus.exc_valid || bus.eret_valid);
    if (accept_s) begin
      req_d.is_eret    = !bus.exc_valid;
      req_d.code       = bus.exc_code;
      req_d.pc         = bus.exc_pc;
      req_d.in_ds      = bus.exc_in_delay_slot;
      req_d.badv_valid = bus.exc_badvaddr_valid;
      req_d.badvaddr   = bus.exc_badvaddr;
      req_d.status     = wb_bypass(bus.cp0_status_in, bus.wb_cp0_write_flag,
                                   bus.wb_cp0_write_addr, bus.wb_cp0_data_in, CP0_ADDR_STATUS);
      req_d.cause      = wb_bypass(bus.cp0_cause_in, bus.wb_cp0_write_flag,
                                   bus.wb_cp0_write_addr, bus.wb_cp0_data_in, CP0_ADDR_CAUSE);
      req_d.epc        = wb_bypass(bus.cp0_epc_in, bus.wb_cp0_write_flag,
                                   bus.wb_cp0_write_addr, bus.wb_cp0_data_in, CP0_ADDR_EPC);
    end else begin
      req_d = req_q;
    end
    exl_s = req_d.status[1];
  end

  // Next-state selection; optional states are skipped without spending a cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!accept_s) begin
          state_d = IDLE;
        end else if (req_d.is_eret) begin
          state_d = E_STATUS;
        end else if (req_d.badv_valid) begin
          state_d = W_BADV;
        end else if (!exl_s) begin
          state_d = W_EPC;
        end else begin
          state_d = W_CAUSE;
        end
      end
      W_BADV:   state_d = exl_s ? W_CAUSE : W_EPC;
      W_EPC:    state_d = W_CAUSE;
      W_CAUSE:  state_d = W_STATUS;
      W_STATUS: state_d = REDIRECT;
      E_STATUS: state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs for the state being entered, so they can be registered.
  always_comb begin
    wr_flag_d  = 1'b0;
    wr_addr_d  = 8'h00;
    wr_data_d  = 32'h0000_0000;
    redir_pc_d = 32'h0000_0000;
    case (state_d)
      W_BADV: begin
        wr_flag_d = 1'b1;
        wr_addr_d = CP0_ADDR_BADVADDR;
        wr_data_d = req_d.badvaddr;
      end
      W_EPC: begin
        wr_flag_d = 1'b1;
        wr_addr_d = CP0_ADDR_EPC;
        wr_data_d = epc_value(req_d.pc, req_d.in_ds);
      end
      W_CAUSE: begin
        wr_flag_d = 1'b1;
        wr_addr_d = CP0_ADDR_CAUSE;
        wr_data_d = cause_value(req_d.cause, req_d.code, req_d.in_ds, exl_s);
      end
      W_STATUS: begin
        wr_flag_d = 1'b1;
        wr_addr_d = CP0_ADDR_STATUS;
        wr_data_d = req_d.status | STATUS_EXL_MASK;
      end
      E_STATUS: begin
        wr_flag_d = 1'b1;
        wr_addr_d = CP0_ADDR_STATUS;
        wr_data_d = req_d.status & ~STATUS_EXL_MASK;
      end
      REDIRECT: begin
        redir_pc_d = req_d.is_eret ? req_d.epc : EXC_VECTOR;
      end
      default: begin
        wr_flag_d  = 1'b0;
        redir_pc_d = 32'h0000_0000;
      end
    endcase
    busy_d        = (state_d != IDLE);
    redir_valid_d = (state_d == REDIRECT);
    flush_d       = accept_s;
  end

  // State, latch bank and registered FSM outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= '0;
      wr_flag_q     <= 1'b0;
      wr_addr_q     <= 8'h00;
      wr_data_q     <= 32'h0000_0000;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      wr_flag_q     <= wr_flag_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  // Write-port mux: WB owns the port only while idle.
  assign bus.cp0_write_flag = (state_q == IDLE) ? bus.wb_cp0_write_flag : wr_flag_q;
  assign bus.cp0_write_addr = (state_q == IDLE) ? bus.wb_cp0_write_addr : wr_addr_q;
  assign bus.cp0_write_data = (state_q == IDLE) ? bus.wb_cp0_data_in    : wr_data_q;

  assign bus.stall_req      = busy_q;
  assign bus.busy           = busy_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redir_valid_q;
  assign bus.redirect_pc    = redir_pc_q;

endmodule
